// File: rtl/pim_conv_sequencer_if.sv
// Handshake bundle between the activation buffer, the sequencer and one crossbar.
// The master modport is the sequencer side; slave is its environment.
interface pim_conv_sequencer_if #(
    parameter int CROSS_SIZE = 64,
    parameter int DEPTH      = 6,
    parameter int ADC_P      = 8,
    parameter int IN_BITS    = 8
);
    localparam int ACC_W = ADC_P + IN_BITS;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DEPTH-1:0]      cmd_addr;

    logic                  plane_valid;
    logic                  plane_ready;
    logic [CROSS_SIZE-1:0] plane_data;

    logic                  pim_en;
    logic [CROSS_SIZE-1:0] pim_input;
    logic [DEPTH-1:0]      pim_address;
    logic [ADC_P-1:0]      pim_output;

    logic                  res_valid;
    logic                  res_ready;
    logic [ACC_W-1:0]      res_data;
    logic [DEPTH-1:0]      res_addr;

    modport master (
        input  cmd_valid,
        input  cmd_addr,
        output cmd_ready,
        input  plane_valid,
        input  plane_data,
        output plane_ready,
        output pim_en,
        output pim_input,
        output pim_address,
        input  pim_output,
        output res_valid,
        input  res_ready,
        output res_data,
        output res_addr
    );

    modport slave (
        output cmd_valid,
        output cmd_addr,
        input  cmd_ready,
        output plane_valid,
        output plane_data,
        input  plane_ready,
        input  pim_en,
        input  pim_input,
        input  pim_address,
        output pim_output,
        input  res_valid,
        output res_ready,
        input  res_data,
        input  res_addr
    );
endinterface

// File: rtl/pim_conv_sequencer.sv
// Bit-serial conv sequencer: one crossbar access per activation bit-plane,
// ADC results shift-accumulated into a full-precision dot product.
module pim_conv_sequencer #(
    parameter int CROSS_SIZE = 64,
    parameter int DEPTH      = 6,
    parameter int ADC_P      = 8,
    parameter int IN_BITS    = 8,
    parameter int PIM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    pim_conv_sequencer_if.master  bus
);
    localparam int ACC_W = ADC_P + IN_BITS;
    localparam int CNT_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1;
    localparam int WT_W  = $clog2(PIM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    state_e                state_q;
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      acc_d;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [WT_W-1:0]       wait_cnt_q;
    logic                  last_plane;

    logic                  pim_en_q;
    logic [CROSS_SIZE-1:0] pim_input_q;
    logic [DEPTH-1:0]      pim_address_q;
    logic                  res_valid_q;
    logic [ACC_W-1:0]      res_data_q;
    logic [DEPTH-1:0]      res_addr_q;

    // ACC_W is wide enough that the shifted partial sum never wraps.
    assign acc_d = acc_q + (ACC_W'(bus.pim_output) << bit_cnt_q);
    assign last_plane = (bit_cnt_q == CNT_W'(IN_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            bit_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            pim_en_q      <= 1'b0;
            pim_input_q   <= '0;
            pim_address_q <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_addr_q    <= '0;
        end else begin
            pim_en_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        pim_address_q <= bus.cmd_addr;
                        res_addr_q    <= bus.cmd_addr;
                        acc_q         <= '0;
                        bit_cnt_q     <= '0;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.plane_valid) begin
                        pim_input_q <= bus.plane_data;
                        pim_en_q    <= 1'b1;
                        wait_cnt_q  <= WT_W'(PIM_LAT);
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    // The ADC sample edge closes the cycle in which the count is zero.
                    if (wait_cnt_q != '0) begin
                        wait_cnt_q <= wait_cnt_q - WT_W'(1);
                    end else begin
                        acc_q <= acc_d;
                        if (last_plane) begin
                            res_valid_q <= 1'b1;
                            res_data_q  <= acc_d;
                            state_q     <= DONE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            state_q   <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.plane_ready = (state_q == ISSUE);
    assign bus.pim_en      = pim_en_q;
    assign bus.pim_input   = pim_input_q;
    assign bus.pim_address = pim_address_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_addr    = res_addr_q;
endmodule

// File: tb/tb_pim_conv_sequencer.sv
// Directed bench for pim_conv_sequencer with a latency-windowed crossbar model
// (PIM_LAT=1 instance for most scenarios, PIM_LAT=3 instance for timing).
module tb_pim_conv_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    pim_conv_sequencer_if b1();
    pim_conv_sequencer_if b3();

    pim_conv_sequencer #(.PIM_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));
    pim_conv_sequencer #(.PIM_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.master));

    logic [2:0] h1 = '0;
    logic [2:0] h3 = '0;
    int pc1 = 0, pc3 = 0, base1 = 0;
    bit mode1 = 1'b0;
    logic [7:0] xval1 = '0, xval3 = '0;
    logic prev1 = 1'b0, prev3 = 1'b0;
    int wide1 = 0, wide3 = 0, ph1 = 0, ill1 = 0;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        h1    <= {h1[1:0], b1.pim_en};
        h3    <= {h3[1:0], b3.pim_en};
        prev1 <= b1.pim_en;
        prev3 <= b3.pim_en;
        if (b1.pim_en) pc1 <= pc1 + 1;
        if (b3.pim_en) pc3 <= pc3 + 1;
        if (b1.pim_en && prev1) wide1 <= wide1 + 1;
        if (b3.pim_en && prev3) wide3 <= wide3 + 1;
        if (b1.plane_valid && b1.plane_ready) ph1 <= ph1 + 1;
        if (b1.plane_ready && (b1.pim_en || b1.res_valid || b1.cmd_ready)) ill1 <= ill1 + 1;
    end

    // Crossbar result is only valid during cycle c+PIM_LAT; garbage elsewhere.
    assign b1.pim_output = h1[0] ? (mode1 ? 8'(pc1 - base1 - 1) : xval1) : 8'hA5;
    assign b3.pim_output = h3[2] ? xval3 : 8'h5A;

    task automatic do_job(input logic [5:0] addr, input int gap_max, input int hold,
                          output logic [15:0] data, output logic [5:0] raddr,
                          output int cmd_wait, output int npulse,
                          output bit stable, output bit inp_ok, output bit tmo);
        int base, n;
        logic [63:0] pd;
        bit rdy;
        tmo = 0; stable = 1; inp_ok = 1; cmd_wait = 0;
        base = pc1; base1 = pc1;
        while (b1.cmd_ready !== 1'b1 && cmd_wait < 100) begin
            @(posedge clk); #1; cmd_wait++;
        end
        if (cmd_wait >= 100) tmo = 1;
        b1.cmd_valid = 1'b1; b1.cmd_addr = addr;
        @(posedge clk); #1;
        b1.cmd_valid = 1'b0; b1.cmd_addr = '1;
        for (int p = 0; p < 8; p++) begin
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            pd = {$urandom, $urandom} ^ 64'(p);
            b1.plane_valid = 1'b1; b1.plane_data = pd;
            n = 0; rdy = 1'b0;
            while (!rdy && n < 100) begin
                rdy = b1.plane_ready;
                @(posedge clk); #1; n++;
            end
            if (!rdy) tmo = 1;
            b1.plane_valid = 1'b0; b1.plane_data = '0;
            if (!(b1.pim_en === 1'b1 && b1.pim_input === pd)) inp_ok = 0;
        end
        n = 0;
        while (b1.res_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) tmo = 1;
        data = b1.res_data; raddr = b1.res_addr;
        repeat (hold) begin
            @(posedge clk); #1;
            if (b1.res_valid !== 1'b1 || b1.res_data !== data ||
                b1.res_addr !== raddr || b1.cmd_ready !== 1'b0) stable = 0;
        end
        b1.res_ready = 1'b1;
        @(posedge clk); #1;
        b1.res_ready = 1'b0;
        npulse = pc1 - base;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (b1.pim_en !== 1'b0) begin errors++; $display("FAIL rst_pim_en got %b exp 0", b1.pim_en); end
        vectors++; if (b1.pim_input !== 64'h0) begin errors++; $display("FAIL rst_pim_input got %h exp 0", b1.pim_input); end
        vectors++; if (b1.pim_address !== 6'h0) begin errors++; $display("FAIL rst_pim_address got %h exp 0", b1.pim_address); end
        vectors++; if (b1.res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", b1.res_valid); end
        vectors++; if (b1.res_data !== 16'h0) begin errors++; $display("FAIL rst_res_data got %h exp 0", b1.res_data); end
        vectors++; if (b1.res_addr !== 6'h0) begin errors++; $display("FAIL rst_res_addr got %h exp 0", b1.res_addr); end
        vectors++; if (b1.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", b1.cmd_ready); end
        vectors++; if (b1.plane_ready !== 1'b0) begin errors++; $display("FAIL rst_plane_ready got %b exp 0", b1.plane_ready); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        int n = 0;
        bit seen_rv = 0, seen_en = 0;
        b1.cmd_valid = 1'b1; b1.cmd_addr = 6'h2A;
        @(posedge clk); #1;
        b1.cmd_valid = 1'b0;
        b1.plane_valid = 1'b1; b1.plane_data = 64'hFFFF_0000_FFFF_0000;
        while (b1.pim_en !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        vectors++; if (n >= 20) begin errors++; $display("FAIL midrst_reach_wait got timeout exp pim_en"); end
        rst = 1'b0;
        #1;
        vectors++; if (b1.pim_en !== 1'b0) begin errors++; $display("FAIL midrst_pim_en got %b exp 0", b1.pim_en); end
        vectors++; if (b1.pim_input !== 64'h0) begin errors++; $display("FAIL midrst_pim_input got %h exp 0", b1.pim_input); end
        vectors++; if (b1.pim_address !== 6'h0) begin errors++; $display("FAIL midrst_pim_address got %h exp 0", b1.pim_address); end
        vectors++; if (b1.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_cmd_ready got %b exp 1", b1.cmd_ready); end
        @(posedge clk); #1;
        rst = 1'b1;
        b1.plane_valid = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (b1.res_valid !== 1'b0) seen_rv = 1;
            if (b1.pim_en !== 1'b0) seen_en = 1;
        end
        vectors++; if (seen_rv) begin errors++; $display("FAIL midrst_no_result got res_valid=1 exp 0"); end
        vectors++; if (seen_en) begin errors++; $display("FAIL midrst_no_access got pim_en=1 exp 0"); end
        vectors++; if (b1.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle got cmd_ready=%b exp 1", b1.cmd_ready); end
    endtask

    task automatic test_const3();
        logic [15:0] d; logic [5:0] a; int cw, np; bit st, ok, to;
        mode1 = 0; xval1 = 8'd3;
        do_job(6'd5, 0, 0, d, a, cw, np, st, ok, to);
        vectors++; if (to) begin errors++; $display("FAIL const3_timeout got 1 exp 0"); end
        vectors++; if (d !== 16'd765) begin errors++; $display("FAIL const3_res_data got %0d exp 765", d); end
        vectors++; if (a !== 6'd5) begin errors++; $display("FAIL const3_res_addr got %0d exp 5", a); end
        vectors++; if (np !== 8) begin errors++; $display("FAIL const3_pulses got %0d exp 8", np); end
        vectors++; if (!ok) begin errors++; $display("FAIL const3_pim_input got bad exp plane data"); end
        vectors++; if (b1.pim_address !== 6'd5) begin errors++; $display("FAIL const3_pim_address got %0d exp 5", b1.pim_address); end
        vectors++; if (wide1 !== 0) begin errors++; $display("FAIL const3_pulse_width got %0d wide exp 0", wide1); end
    endtask

    task automatic test_full_scale();
        logic [15:0] d; logic [5:0] a; int cw, np; bit st, ok, to;
        mode1 = 0; xval1 = 8'd255;
        do_job(6'h3F, 1, 0, d, a, cw, np, st, ok, to);
        vectors++; if (to) begin errors++; $display("FAIL full_timeout got 1 exp 0"); end
        vectors++; if (d !== 16'hFE01) begin errors++; $display("FAIL full_res_data got %h exp fe01", d); end
        vectors++; if (a !== 6'h3F) begin errors++; $display("FAIL full_res_addr got %h exp 3f", a); end
    endtask

    task automatic test_plane_index();
        logic [15:0] d; logic [5:0] a; int cw, np, ph0; bit st, ok, to;
        mode1 = 1; ph0 = ph1;
        do_job(6'd9, 3, 0, d, a, cw, np, st, ok, to);
        mode1 = 0;
        vectors++; if (to) begin errors++; $display("FAIL index_timeout got 1 exp 0"); end
        vectors++; if (d !== 16'd1538) begin errors++; $display("FAIL index_res_data got %0d exp 1538", d); end
        vectors++; if (a !== 6'd9) begin errors++; $display("FAIL index_res_addr got %0d exp 9", a); end
        vectors++; if (ph1 - ph0 !== 8) begin errors++; $display("FAIL index_planes got %0d exp 8", ph1 - ph0); end
        vectors++; if (ill1 !== 0) begin errors++; $display("FAIL index_plane_ready got %0d bad cycles exp 0", ill1); end
        vectors++; if (!ok) begin errors++; $display("FAIL index_pim_input got bad exp plane data"); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d; logic [5:0] a; int cw, np; bit st, ok, to;
        mode1 = 0; xval1 = 8'd1;
        do_job(6'd12, 0, 10, d, a, cw, np, st, ok, to);
        vectors++; if (to) begin errors++; $display("FAIL hold_timeout got 1 exp 0"); end
        vectors++; if (d !== 16'd255) begin errors++; $display("FAIL hold_res_data got %0d exp 255", d); end
        vectors++; if (!st) begin errors++; $display("FAIL hold_stable got unstable exp stable"); end
        vectors++; if (b1.cmd_ready !== 1'b1) begin errors++; $display("FAIL hold_cmd_ready got %b exp 1", b1.cmd_ready); end
        vectors++; if (b1.res_valid !== 1'b0) begin errors++; $display("FAIL hold_res_valid got %b exp 0", b1.res_valid); end
        xval1 = 8'd2;
        do_job(6'd13, 0, 0, d, a, cw, np, st, ok, to);
        vectors++; if (cw !== 0) begin errors++; $display("FAIL b2b_cmd_wait got %0d exp 0", cw); end
        vectors++; if (d !== 16'd510) begin errors++; $display("FAIL b2b_res_data got %0d exp 510", d); end
        vectors++; if (a !== 6'd13) begin errors++; $display("FAIL b2b_res_addr got %0d exp 13", a); end
    endtask

    task automatic test_latency3();
        int t[8];
        int n = 0, k = 0;
        bit gap_ok = 1;
        xval3 = 8'd7;
        b3.cmd_valid = 1'b1; b3.cmd_addr = 6'd33;
        @(posedge clk); #1;
        b3.cmd_valid = 1'b0;
        b3.plane_valid = 1'b1; b3.plane_data = 64'h0123_4567_89AB_CDEF;
        while (b3.res_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1; n++;
            if (b3.pim_en === 1'b1) begin
                if (k < 8) t[k] = cyc;
                k++;
            end
        end
        b3.plane_valid = 1'b0;
        vectors++; if (n >= 200) begin errors++; $display("FAIL lat3_timeout got timeout exp res_valid"); end
        vectors++; if (k !== 8) begin errors++; $display("FAIL lat3_pulses got %0d exp 8", k); end
        for (int i = 1; i < 8; i++) if (k == 8 && t[i] - t[i-1] != 5) gap_ok = 0;
        vectors++; if (!gap_ok) begin errors++; $display("FAIL lat3_plane_period got irregular exp 5 cycles"); end
        vectors++; if (wide3 !== 0) begin errors++; $display("FAIL lat3_pulse_width got %0d wide exp 0", wide3); end
        vectors++; if (b3.res_data !== 16'd1785) begin errors++; $display("FAIL lat3_res_data got %0d exp 1785", b3.res_data); end
        vectors++; if (b3.res_addr !== 6'd33) begin errors++; $display("FAIL lat3_res_addr got %0d exp 33", b3.res_addr); end
        b3.res_ready = 1'b1;
        @(posedge clk); #1;
        b3.res_ready = 1'b0;
        vectors++; if (b3.cmd_ready !== 1'b1) begin errors++; $display("FAIL lat3_idle got cmd_ready=%b exp 1", b3.cmd_ready); end
    endtask

    initial begin
        b1.cmd_valid = 0; b1.cmd_addr = '0; b1.plane_valid = 0;
        b1.plane_data = '0; b1.res_ready = 0;
        b3.cmd_valid = 0; b3.cmd_addr = '0; b3.plane_valid = 0;
        b3.plane_data = '0; b3.res_ready = 0;
        test_reset();
        test_reset_mid_wait();
        test_const3();
        test_full_scale();
        test_plane_index();
        test_back_to_back();
        test_latency3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end
endmodule
